alu_sequencer: RTL and testbench

Sequential command front-end for the 8-bit arithmetic datapath. Accepts one operation (opcode plus two operands) per valid/ready handshake, executes it (single-cycle for add/sub/compare, 8-cycle iterative shift-add multiply and restoring divide), and returns a registered result with status flags over a second valid/ready handshake. It is the initiator side that issues work to and collects results from the arithmetic cells. It is the only block that talks to the pad-level command logic.

---
 rtl/alu_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command front-end for the 8-bit arithmetic datapath. It accepts one
//   operation per cmd handshake, executes it, and returns a registered result
//   with status flags over the rsp handshake. Add/sub/compare, the reserved
//   opcode and divide-by-zero finish in one cycle. Multiply (shift-add) and
//   divide (restoring) take WIDTH iterations, one per cycle.
//
// Ports
//   clk        in   single clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  block can accept a command (IDLE only)
//   cmd_op     in   0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 reserved, 5 EQ, 6 GT, 7 LT
//   cmd_a      in   operand A (unsigned)
//   cmd_b      in   operand B (unsigned)
//   rsp_valid  out  result present (DONE only)
//   rsp_ready  in   consumer takes result
//   rsp_data   out  result, 2*WIDTH bits
//   rsp_flag   out  [0] zero, [1] carry/borrow/overflow, [2] error
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for a command; op/a/b latched on handshake
// EXEC  | computing; one cycle, or WIDTH iterations for MUL / DIV b!=0
// DONE  | rsp_valid=1, result held until rsp_ready

module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic [2:0]         rsp_flag
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_RSV = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_LT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      iter_cnt;

  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_mc;
  logic [WIDTH-1:0]   mul_mq;

  // Restoring divider: quotient register starts as the dividend and shifts
  // its MSB into the partial remainder each iteration.
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;

  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_fit;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;

  logic               is_iter;
  logic               iter_last;
  logic [2*WIDTH-1:0] iter_data;
  logic               iter_cy;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] sc_data;
  logic               sc_cy;
  logic               sc_err;

  assign is_iter   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
  assign iter_last = (iter_cnt == CW'(WIDTH - 1));

  always_comb begin
    mul_next     = mul_mq[0] ? (mul_prod + mul_mc) : mul_prod;
    div_shift    = {div_rem, div_quo[WIDTH-1]};
    div_fit      = (div_shift >= {1'b0, b_q});
    div_rem_next = div_fit ? WIDTH'(div_shift - {1'b0, b_q})
                           : div_shift[WIDTH-1:0];
    div_quo_next = {div_quo[WIDTH-2:0], div_fit};

    if (op_q == OP_MUL) begin
      iter_data = mul_next;
      iter_cy   = (mul_next[2*WIDTH-1:WIDTH] != '0);
    end else begin
      iter_data = {div_rem_next, div_quo_next};
      iter_cy   = 1'b0;
    end
  end

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    sc_data = '0;
    sc_cy   = 1'b0;
    sc_err  = 1'b0;
    case (op_q)
      OP_ADD: begin
        sc_data = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        sc_cy   = sum[WIDTH];
      end
      OP_SUB: begin
        sc_data = {{WIDTH{1'b0}}, WIDTH'(a_q - b_q)};
        sc_cy   = (a_q < b_q);
      end
      OP_EQ:   sc_data = {{(2*WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_GT:   sc_data = {{(2*WIDTH-1){1'b0}}, (a_q >  b_q)};
      OP_LT:   sc_data = {{(2*WIDTH-1){1'b0}}, (a_q <  b_q)};
      // Reserved opcode and divide-by-zero land here; MUL never does.
      OP_RSV, OP_DIV, OP_MUL: sc_err = 1'b1;
      default: sc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
      iter_cnt  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mul_prod  <= '0;
      mul_mc    <= '0;
      mul_mq    <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            a_q       <= cmd_a;
            b_q       <= cmd_b;
            iter_cnt  <= '0;
            mul_prod  <= '0;
            mul_mc    <= {{WIDTH{1'b0}}, cmd_a};
            mul_mq    <= cmd_b;
            div_rem   <= '0;
            div_quo   <= cmd_a;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end

        EXEC: begin
          if (!is_iter) begin
            rsp_data  <= sc_data;
            rsp_flag  <= {sc_err, sc_cy, (sc_data == '0)};
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
            mul_prod <= mul_next;
            mul_mc   <= {mul_mc[2*WIDTH-2:0], 1'b0};
            mul_mq   <= {1'b0, mul_mq[WIDTH-1:1]};
            div_rem  <= div_rem_next;
            div_quo  <= div_quo_next;
            if (iter_last) begin
              rsp_data  <= iter_data;
              rsp_flag  <= {1'b0, iter_cy, (iter_data == '0)};
              rsp_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flag;

  int n_chk  = 0;
  int n_fail = 0;

  alu_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flag  (rsp_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] d;
    logic [2:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, output logic [15:0] d,
                                output logic [2:0] f, output int lat);
    int ia, ib, r;
    logic cy, err;
    ia = int'(a); ib = int'(b);
    cy = 1'b0; err = 1'b0; lat = 1; r = 0;
    case (op)
      3'd0: begin r = (ia + ib) % 256; cy = (ia + ib) > 255; end
      3'd1: begin r = (ia - ib + 256) % 256; cy = ia < ib; end
      3'd2: begin r = ia * ib; cy = r > 255; lat = 8; end
      3'd3: if (ib == 0) err = 1'b1;
            else begin r = (ia % ib) * 256 + ia / ib; lat = 8; end
      3'd4: err = 1'b1;
      3'd5: r = (ia == ib) ? 1 : 0;
      3'd6: r = (ia > ib) ? 1 : 0;
      default: r = (ia < ib) ? 1 : 0;
    endcase
    d = 16'(r);
    f = {err, cy, (r == 0)};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 30) begin tick(); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command, measure latency, optionally stall, then take result.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int stall, output logic [15:0] d,
                         output logic [2:0] f, output int lat);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    chk("cmd_ready_low_after_accept", 32'(cmd_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    d = rsp_data; f = rsp_flag;
    if (stall > 0) begin
      repeat (stall) tick();
      chk("stall_valid_held", 32'(rsp_valid), 32'd1);
      chk("stall_data_stable", 32'(rsp_data), 32'(d));
      chk("stall_flag_stable", 32'(rsp_flag), 32'(f));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid_low", 32'(rsp_valid), 32'd0);
    chk("post_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d, ed;
    logic [2:0]  f, ef;
    int          lat, el, cnt;
    logic [2:0]  rop;
    logic [7:0]  ra, rb;

    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h002C, 3'b010, 1};
    vecs[1]  = '{3'd1, 8'd3,   8'd5,   16'h00FE, 3'b010, 1};
    vecs[2]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 3'b010, 8};
    vecs[3]  = '{3'd2, 8'd0,   8'd7,   16'h0000, 3'b001, 8};
    vecs[4]  = '{3'd3, 8'd200, 8'd7,   16'h041C, 3'b000, 8};
    vecs[5]  = '{3'd3, 8'd9,   8'd0,   16'h0000, 3'b101, 1};
    vecs[6]  = '{3'd6, 8'd5,   8'd3,   16'h0001, 3'b000, 1};
    vecs[7]  = '{3'd7, 8'd5,   8'd3,   16'h0000, 3'b001, 1};
    vecs[8]  = '{3'd5, 8'h80,  8'h80,  16'h0001, 3'b000, 1};
    vecs[9]  = '{3'd4, 8'd17,  8'd42,  16'h0000, 3'b101, 1};
    vecs[10] = '{3'd0, 8'd0,   8'd0,   16'h0000, 3'b001, 1};
    vecs[11] = '{3'd0, 8'd128, 8'd128, 16'h0000, 3'b011, 1};
    vecs[12] = '{3'd3, 8'd255, 8'd1,   16'h00FF, 3'b000, 8};
    vecs[13] = '{3'd3, 8'd5,   8'd9,   16'h0500, 3'b000, 8};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  32'(rsp_data),  32'h0);
    chk("reset_rsp_flag",  32'(rsp_flag),  32'h0);

    // Directed table
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 0, d, f, lat);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].d));
      chk($sformatf("vec%0d_flag", i), 32'(f), 32'(vecs[i].f));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure on MUL 12*13 with an ignored cmd_valid pulse mid-stall
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'd12; cmd_b = 8'd13;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("bp_lat", 32'(lat), 32'd8);
    chk("bp_data", 32'(rsp_data), 32'h009C);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'd1; cmd_b = 8'd1; end
      tick();
      cmd_valid = 1'b0;
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_data_held", 32'(rsp_data), 32'h009C);
      chk("bp_flag_held", 32'(rsp_flag), 32'b000);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_idle", 32'(cmd_ready), 32'd1);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    cnt = 0;
    repeat (3) begin tick(); if (rsp_valid) cnt++; end
    chk("bp_pulse_not_queued", 32'(cnt), 32'd0);
    run_cmd(3'd0, 8'd7, 8'd8, 0, d, f, lat);
    chk("bp_next_data", 32'(d), 32'h000F);
    chk("bp_next_lat", 32'(lat), 32'd1);

    // Reset during MUL iteration 4
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'd100; cmd_b = 8'd200;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmul_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstmul_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmul_rsp_data", 32'(rsp_data), 32'h0);
    chk("rstmul_rsp_flag", 32'(rsp_flag), 32'h0);
    cnt = 0;
    repeat (10) begin tick(); if (rsp_valid) cnt++; end
    chk("rstmul_discarded", 32'(cnt), 32'd0);
    run_cmd(3'd0, 8'd1, 8'd1, 0, d, f, lat);
    chk("rstmul_add_data", 32'(d), 32'h0002);
    chk("rstmul_add_flag", 32'(f), 32'b000);
    chk("rstmul_add_lat", 32'(lat), 32'd1);

    // Reset coinciding with a response handshake clears the outputs
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'd200; cmd_b = 8'd100;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    rst = 1'b1; rsp_ready = 1'b1;
    tick();
    rst = 1'b0; rsp_ready = 1'b0;
    chk("rstdone_data", 32'(rsp_data), 32'h0);
    chk("rstdone_flag", 32'(rsp_flag), 32'h0);
    chk("rstdone_valid", 32'(rsp_valid), 32'd0);
    chk("rstdone_ready", 32'(cmd_ready), 32'd1);

    // Randomized against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      rb  = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) tick();
      model(rop, ra, rb, ed, ef, el);
      run_cmd(rop, ra, rb, $urandom_range(0, 3), d, f, lat);
      chk($sformatf("rand%0d_op%0d_%0d_%0d_data", i, rop, ra, rb), 32'(d), 32'(ed));
      chk($sformatf("rand%0d_op%0d_%0d_%0d_flag", i, rop, ra, rb), 32'(f), 32'(ef));
      chk($sformatf("rand%0d_op%0d_lat", i, rop), 32'(lat), 32'(el));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
